driver_7_segmentos: RTL and testbench
=====================================

Name: driver_7_segmentos

Overview:
Downstream consumer of the 0-3 digit-scan counter in the 7-segment peripheral. It takes the 2-bit digit index and a 16-bit value written by the processor bus, and drives the four anode lines and the seven segment lines.
- Double-buffered data register: a new value only reaches the display at the start of a scan frame.
- Fixed blanking dead time on every digit change, to prevent ghosting.
- Optional leading-zero suppression.

Parameters:
BLANK_CYCLES, 8, clock cycles with all anodes off after each digit change (legal range 1..255).

Ports:
clk_10MHz_i  in   1   system clock, 10 MHz
rst_i        in   1   reset, synchronous, active-low (rst_i=0 resets on the rising edge of clk_10MHz_i)
digito_i     in   2   current digit index from the scan counter (0 = least significant digit)
we_i         in   1   bus write strobe, one cycle, captures dato_i
dato_i       in   16  value to display, 4 hex nibbles, nibble k on digit k
lzs_en_i     in   1   1 = leading-zero suppression enabled
dato_o       out  16  readback of the last written value (shadow register)
pendiente_o  out  1   1 = shadow written but not yet transferred to the display
an_o         out  4   anodes, active-low, an_o[k] selects digit k
seg_o        out  7   segments, active-low, {g,f,e,d,c,b,a}

Behaviour:
- Reset (rst_i=0 at an edge) sets:
  - shadow, visible register, dato_o = 16'h0000; pendiente_o = 0
  - digito_r = 0; cnt = 0; state = BLANK
  - an_o = 4'hF; seg_o = 7'h7F
- Registers and outputs:
  - All outputs are registered.
  - Reset has priority over every other event.
  - Reset mid-blank or mid-frame discards pending data.
- Write:
  - we_i=1 at an edge: shadow <= dato_i; pendiente_o <= 1.
  - dato_o reflects the new value from the next cycle.
  - Back-to-back writes: the last one wins.
- Digit change: chg = (digito_i != digito_r), evaluated each cycle. At an edge with chg=1:
  - digito_r <= digito_i
  - state <= BLANK, cnt <= 0, an_o <= 4'hF, seg_o <= 7'h7F
- Frame transfer:
  - Occurs at a chg edge where digito_i == 0 and pendiente_o == 1.
  - Visible register <= shadow; pendiente_o <= 0.
  - If we_i=1 in the same cycle: the shadow takes dato_i, pendiente_o stays 1, and the visible register takes the old shadow. The new value shows next frame.
- FSM states: BLANK, ON.
  - BLANK, no chg: cnt <= cnt+1. When cnt == BLANK_CYCLES-1, go to ON and load an_o/seg_o for digito_r.
  - BLANK, chg: cnt restarts at 0.
  - ON: an_o = ~(4'b0001 << digito_r); seg_o = decode(visible nibble digito_r). Hold until chg.
  - Dead time: exactly BLANK_CYCLES cycles of an_o = 4'hF after the chg edge. The anode goes active after edge N+BLANK_CYCLES.
  - ON with chg at every edge (index changing every cycle) keeps the FSM in BLANK permanently.
- Visible-register change while ON: seg_o updates the cycle after the transfer. This only happens at digit-0 chg, so it is always within BLANK.
- Leading-zero suppression:
  - Applies to digit k (k=3,2,1) when lzs_en_i=1 and visible nibbles k..3 are all zero.
  - A suppressed digit in ON drives an_o = 4'hF and seg_o = 7'h7F.
  - Digit 0 is never suppressed.
  - lzs_en_i is sampled when entering ON and while ON.
- Decode (hex, active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Test Plan:
1. Reset, then digito_i held 0, BLANK_CYCLES=8 -> an_o=F, seg_o=7F for 8 cycles after reset release, then an_o=E, seg_o=40.
2. Write 16'h12AF mid-frame at digit 2 -> dato_o=12AF and pendiente_o=1 next cycle; display unchanged until digito_i 3->0; then pendiente_o=0.
   - Next frame: digit0 seg 0E, digit1 08, digit2 24, digit3 79; anodes E, D, B, 7.
3. Digit change 1->2 -> an_o=F for exactly BLANK_CYCLES cycles, then an_o=B. A second change to 3 during blank restarts cnt; an_o=7 only after a full BLANK_CYCLES from the second change.
4. lzs_en_i=1, value 16'h0005 -> digits 3, 2, 1 give an_o=F, seg_o=7F; digit 0 gives an_o=E, seg_o=12.
   - Value 16'h0000 -> only digit 0 lit, showing 40.
   - lzs_en_i=0 -> all four digits show 40.
5. we_i=1 with dato_i=16'hBEEF on the same edge as the 3->0 transfer of shadow 16'h1234 -> this frame displays 1234; pendiente_o=1; next frame displays BEEF.
6. rst_i=0 for one edge while ON with pendiente_o=1 -> the next cycle shows an_o=F, seg_o=7F, dato_o=0000, pendiente_o=0, and the blank sequence restarts.

Source files
------------

// File: rtl/driver_7_segmentos.sv
// Four-digit 7-segment driver: double-buffered display register, fixed
// blanking dead time on every digit change and optional leading-zero suppression.
module driver_7_segmentos #(
   parameter int unsigned BLANK_CYCLES = 8
) (
   input  logic        clk_10MHz_i,
   input  logic        rst_i,
   input  logic [1:0]  digito_i,
   input  logic        we_i,
   input  logic [15:0] dato_i,
   input  logic        lzs_en_i,
   output logic [15:0] dato_o,
   output logic        pendiente_o,
   output logic [3:0]  an_o,
   output logic [6:0]  seg_o
);

   typedef enum logic {BLANK, ON} state_t;

   localparam logic [7:0] CNT_LAST = 8'(BLANK_CYCLES - 1);

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic [1:0]  digito_r, digito_n;
   logic [15:0] visible, visible_n;
   logic [15:0] shadow_n;
   logic        pend_n;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;

   logic        chg;
   logic [3:0]  nibble;
   logic        suppress;
   logic [3:0]  an_lit;
   logic [6:0]  seg_lit;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Lit pattern for the held digit; a digit is suppressed when it and all higher nibbles are zero.
   always_comb begin
      nibble   = visible[3:0];
      suppress = 1'b0;
      case (digito_r)
         2'd0: begin
            nibble   = visible[3:0];
            suppress = 1'b0;
         end
         2'd1: begin
            nibble   = visible[7:4];
            suppress = lzs_en_i && (visible[15:4] == '0);
         end
         2'd2: begin
            nibble   = visible[11:8];
            suppress = lzs_en_i && (visible[15:8] == '0);
         end
         default: begin
            nibble   = visible[15:12];
            suppress = lzs_en_i && (visible[15:12] == '0);
         end
      endcase
      an_lit  = suppress ? '1 : ~(4'b0001 << digito_r);
      seg_lit = suppress ? '1 : decode(nibble);
   end

   assign chg = (digito_i != digito_r);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      digito_n  = digito_r;
      visible_n = visible;
      shadow_n  = dato_o;
      pend_n    = pendiente_o;
      an_n      = an_o;
      seg_n     = seg_o;

      // Transfer takes the old shadow first, so a coincident write lands in the next frame.
      if (chg && (digito_i == 2'd0) && pendiente_o) begin
         visible_n = dato_o;
         pend_n    = 1'b0;
      end
      if (we_i) begin
         shadow_n = dato_i;
         pend_n   = 1'b1;
      end

      if (chg) begin
         digito_n = digito_i;
         state_n  = BLANK;
         cnt_n    = '0;
         an_n     = '1;
         seg_n    = '1;
      end else begin
         case (state)
            BLANK: begin
               if (cnt == CNT_LAST) begin
                  state_n = ON;
                  an_n    = an_lit;
                  seg_n   = seg_lit;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            default: begin
               an_n  = an_lit;
               seg_n = seg_lit;
            end
         endcase
      end
   end

   always_ff @(posedge clk_10MHz_i) begin
      if (!rst_i) begin
         state       <= BLANK;
         cnt         <= '0;
         digito_r    <= '0;
         visible     <= '0;
         dato_o      <= '0;
         pendiente_o <= 1'b0;
         an_o        <= '1;
         seg_o       <= '1;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         digito_r    <= digito_n;
         visible     <= visible_n;
         dato_o      <= shadow_n;
         pendiente_o <= pend_n;
         an_o        <= an_n;
         seg_o       <= seg_n;
      end
   end

endmodule

// File: tb/tb_driver_7_segmentos.sv
// Self-checking bench for driver_7_segmentos: directed scenarios followed by
// random scanning, compared each cycle against an elapsed-time display model.
module tb_driver_7_segmentos;

   localparam int unsigned BLANK = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  digito = 2'd0;
   logic        we = 1'b0;
   logic [15:0] dato = 16'h0000;
   logic        lzs = 1'b0;
   logic [15:0] dato_o;
   logic        pendiente_o;
   logic [3:0]  an_o;
   logic [6:0]  seg_o;

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state
   int unsigned m_shadow = 0;
   int unsigned m_vis = 0;
   int unsigned m_pend = 0;
   int          m_dig = 0;
   int          m_since = 0;
   logic [3:0]  e_an = 4'hF;
   logic [6:0]  e_seg = 7'h7F;

   driver_7_segmentos #(.BLANK_CYCLES(BLANK)) dut (
      .clk_10MHz_i(clk),
      .rst_i(rst),
      .digito_i(digito),
      .we_i(we),
      .dato_i(dato),
      .lzs_en_i(lzs),
      .dato_o(dato_o),
      .pendiente_o(pendiente_o),
      .an_o(an_o),
      .seg_o(seg_o)
   );

   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      int unsigned upper;
      int unsigned nib;
      if (!rst) begin
         m_shadow = 0; m_vis = 0; m_pend = 0; m_dig = 0; m_since = 0;
      end else begin
         if (int'(digito) != m_dig && digito == 2'd0 && m_pend == 1) begin
            m_vis  = m_shadow;
            m_pend = 0;
         end
         if (we) begin
            m_shadow = dato;
            m_pend   = 1;
         end
         if (int'(digito) != m_dig) begin
            m_dig   = int'(digito);
            m_since = 0;
         end else if (m_since < 1000) begin
            m_since++;
         end
      end
      e_an  = 4'hF;
      e_seg = 7'h7F;
      if (m_since >= int'(BLANK)) begin
         upper = m_vis >> (4 * m_dig);
         nib   = upper & 15;
         if (!(lzs && m_dig != 0 && upper == 0)) begin
            e_an  = 4'((~(1 << m_dig)) & 15);
            e_seg = seg_tab[nib];
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("an_o", {12'h0, an_o}, {12'h0, e_an});
      check("seg_o", {9'h0, seg_o}, {9'h0, e_seg});
      check("dato_o", dato_o, 16'(m_shadow));
      check("pendiente_o", {15'h0, pendiente_o}, {15'h0, 1'(m_pend)});
   endtask

   task automatic hold(input logic [1:0] d, input int n);
      digito = d;
      repeat (n) step();
   endtask

   task automatic write(input logic [15:0] v);
      we = 1'b1;
      dato = v;
      step();
      we = 1'b0;
   endtask

   initial begin
      // 1: reset and first dead time
      rst = 1'b0;
      step(); step();
      check("rst_an", {12'h0, an_o}, 16'h000F);
      check("rst_seg", {9'h0, seg_o}, 16'h007F);
      rst = 1'b1;
      hold(2'd0, 7);
      check("t1_blank_an", {12'h0, an_o}, 16'h000F);
      hold(2'd0, 1);
      check("t1_lit_an", {12'h0, an_o}, 16'h000E);
      check("t1_lit_seg", {9'h0, seg_o}, 16'h0040);

      // 2: write mid-frame, transfer at 3->0
      hold(2'd1, 10);
      hold(2'd2, 3);
      write(16'h12AF);
      check("t2_dato", dato_o, 16'h12AF);
      check("t2_pend", {15'h0, pendiente_o}, 16'h0001);
      hold(2'd2, 8);
      hold(2'd3, 10);
      check("t2_old_seg3", {9'h0, seg_o}, 16'h0040);
      hold(2'd0, 10);
      check("t2_pend_clr", {15'h0, pendiente_o}, 16'h0000);
      check("t2_seg0", {9'h0, seg_o}, 16'h000E);
      check("t2_an0", {12'h0, an_o}, 16'h000E);
      hold(2'd1, 10);
      check("t2_seg1", {9'h0, seg_o}, 16'h0008);
      check("t2_an1", {12'h0, an_o}, 16'h000D);
      hold(2'd2, 10);
      check("t2_seg2", {9'h0, seg_o}, 16'h0024);
      check("t2_an2", {12'h0, an_o}, 16'h000B);
      hold(2'd3, 10);
      check("t2_seg3", {9'h0, seg_o}, 16'h0079);
      check("t2_an3", {12'h0, an_o}, 16'h0007);

      // 3: dead time and restart during blank
      hold(2'd1, 10);
      hold(2'd2, 8);
      check("t3_blank", {12'h0, an_o}, 16'h000F);
      hold(2'd2, 1);
      check("t3_lit", {12'h0, an_o}, 16'h000B);
      hold(2'd1, 10);
      hold(2'd2, 4);
      hold(2'd3, 8);
      check("t3_restart_blank", {12'h0, an_o}, 16'h000F);
      hold(2'd3, 1);
      check("t3_restart_lit", {12'h0, an_o}, 16'h0007);

      // 4: leading-zero suppression
      lzs = 1'b1;
      write(16'h0005);
      hold(2'd3, 2);
      hold(2'd0, 10);
      check("t4_an0", {12'h0, an_o}, 16'h000E);
      check("t4_seg0", {9'h0, seg_o}, 16'h0012);
      hold(2'd1, 10);
      check("t4_an1", {12'h0, an_o}, 16'h000F);
      check("t4_seg1", {9'h0, seg_o}, 16'h007F);
      hold(2'd2, 10);
      hold(2'd3, 10);
      check("t4_an3", {12'h0, an_o}, 16'h000F);
      write(16'h0000);
      hold(2'd0, 10);
      check("t4_zero_seg0", {9'h0, seg_o}, 16'h0040);
      hold(2'd1, 10);
      check("t4_zero_an1", {12'h0, an_o}, 16'h000F);
      lzs = 1'b0;
      hold(2'd1, 2);
      check("t4_nolzs_an1", {12'h0, an_o}, 16'h000D);
      hold(2'd2, 10);
      hold(2'd3, 10);
      check("t4_nolzs_seg3", {9'h0, seg_o}, 16'h0040);

      // 5: write coinciding with transfer
      write(16'h1234);
      hold(2'd3, 2);
      digito = 2'd0;
      write(16'hBEEF);
      check("t5_pend", {15'h0, pendiente_o}, 16'h0001);
      check("t5_dato", dato_o, 16'hBEEF);
      hold(2'd0, 10);
      check("t5_seg0_old", {9'h0, seg_o}, 16'h0019);
      hold(2'd1, 10);
      hold(2'd2, 10);
      hold(2'd3, 10);
      check("t5_seg3_old", {9'h0, seg_o}, 16'h0079);
      hold(2'd0, 10);
      check("t5_seg0_new", {9'h0, seg_o}, 16'h000E);
      check("t5_pend_clr", {15'h0, pendiente_o}, 16'h0000);

      // 6: reset while ON with pending data
      write(16'h5555);
      hold(2'd0, 2);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("t6_an", {12'h0, an_o}, 16'h000F);
      check("t6_seg", {9'h0, seg_o}, 16'h007F);
      check("t6_dato", dato_o, 16'h0000);
      check("t6_pend", {15'h0, pendiente_o}, 16'h0000);
      hold(2'd0, 8);
      check("t6_relit_seg", {9'h0, seg_o}, 16'h0040);

      // Random scanning, writes, suppression toggling and occasional reset
      for (int i = 0; i < 300; i++) begin
         int n;
         digito = 2'($urandom_range(3));
         n = $urandom_range(1, 12);
         if ($urandom_range(7) == 0) lzs = ~lzs;
         for (int j = 0; j < n; j++) begin
            we   = ($urandom_range(7) == 0);
            dato = 16'($urandom);
            if ($urandom_range(2) == 0) dato[15:8] = 8'h00;
            rst  = ($urandom_range(199) != 0);
            step();
         end
         we  = 1'b0;
         rst = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
